// File: rtl/timer_counter.sv
// Memory-mapped countdown timer on the M-stage load/store bus.
// Counts down from PRESET, raises irq on expiry, one-shot or auto-reload.
module timer_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    localparam logic [1:0] MODE_AUTO = 2'd1;

    logic [3:0]       r_ctrl;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic [1:0]       r_state;
    logic             r_irq_pending;
    logic             r_irq;

    logic [3:0]       w_ctrl_nxt;
    logic [WIDTH-1:0] w_preset_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [1:0]       w_state_nxt;
    logic             w_pend_nxt;

    logic w_en;
    logic w_auto;
    logic w_wr_ctrl;
    logic w_wr_preset;

    assign w_en        = r_ctrl[0];
    assign w_auto      = (r_ctrl[2:1] == MODE_AUTO);
    assign w_wr_ctrl   = we && (addr == A_CTRL);
    assign w_wr_preset = we && (addr == A_PRESET);

    always_comb begin
        w_ctrl_nxt   = r_ctrl;
        w_preset_nxt = r_preset;
        w_count_nxt  = r_count;
        w_state_nxt  = r_state;
        w_pend_nxt   = r_irq_pending;

        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > WIDTH'(1)) begin
                    w_count_nxt = r_count - WIDTH'(1);
                end else begin
                    // A count of 0 (PRESET=0) expires like a count of 1.
                    w_count_nxt = '0;
                    w_state_nxt = S_INT;
                    w_pend_nxt  = 1'b1;
                end
            end
            S_INT: begin
                // Auto-reload re-enters via IDLE, so the reload period is PRESET+3.
                w_state_nxt = S_IDLE;
                if (w_auto) begin
                    w_pend_nxt = 1'b0;
                end else begin
                    w_ctrl_nxt[0] = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Software CTRL writes override the FSM's EN clear and any pending set.
        if (w_wr_ctrl) begin
            w_ctrl_nxt = wdata[3:0];
            w_pend_nxt = 1'b0;
        end
        if (w_wr_preset) begin
            w_preset_nxt = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl        <= '0;
            r_preset      <= '0;
            r_count       <= '0;
            r_state       <= S_IDLE;
            r_irq_pending <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_ctrl        <= w_ctrl_nxt;
            r_preset      <= w_preset_nxt;
            r_count       <= w_count_nxt;
            r_state       <= w_state_nxt;
            r_irq_pending <= w_pend_nxt;
            r_irq         <= w_pend_nxt & w_ctrl_nxt[3];
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = '0;
        case (addr)
            A_CTRL:   rdata = {{(WIDTH-4){1'b0}}, r_ctrl};
            A_PRESET: rdata = r_preset;
            A_COUNT:  rdata = r_count;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues expected reads, a
// negedge monitor pops and compares them against rdata/irq.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    timer_counter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        bit          chk_irq;
        bit          irqv;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    int ar_cnt [15] = '{0, 2, 1, 0, 0, 0, 2, 1, 0, 0, 0, 2, 1, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            total++;
            if (m_e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: check missed, queued for cycle %0d, now %0d", m_e.tag, m_e.cyc, cyc);
            end else begin
                if (rdata !== m_e.rd) begin
                    bad++;
                    $display("FAIL %s: rdata got 0x%08h expected 0x%08h", m_e.tag, rdata, m_e.rd);
                end
                if (m_e.chk_irq) begin
                    total++;
                    if (irq !== m_e.irqv) begin
                        bad++;
                        $display("FAIL %s_irq: irq got %b expected %b", m_e.tag, irq, m_e.irqv);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [1:0] a, input logic [31:0] v, input bit ci, input bit iv,
                       input string tag);
        exp_t e;
        addr      = a;
        e.cyc     = cyc;
        e.rd      = v;
        e.chk_irq = ci;
        e.irqv    = iv;
        e.tag     = tag;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        tick();
        tick();
        chk(2'd0, 32'd0, 1, 0, "rst_ctrl");
        reset = 1'b0;
        tick(); chk(2'd1, 32'd0, 1, 0, "rst_preset");
        tick(); chk(2'd2, 32'd0, 1, 0, "rst_count");

        // One-shot, PRESET=3, CTRL=0x9 at edge E
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick();
        tick(); chk(2'd2, 32'd3, 1, 0, "os_cnt3");
        tick(); chk(2'd2, 32'd2, 1, 0, "os_cnt2");
        tick(); chk(2'd2, 32'd1, 1, 0, "os_cnt1");
        tick(); chk(2'd2, 32'd0, 1, 1, "os_cnt0");
        tick(); chk(2'd0, 32'h8, 1, 1, "os_en_clr");
        tick(); chk(2'd0, 32'h8, 1, 1, "os_irq_held");
        wr(2'd0, 32'h0);
        chk(2'd0, 32'h0, 1, 0, "os_irq_clr");

        // Auto-reload, PRESET=2, CTRL=0xB: irq pulses at E+4, E+9, E+14
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk(2'd2, 32'(ar_cnt[k-1]), 1, (k == 4 || k == 9 || k == 14), $sformatf("ar_e%0d", k));
        end
        wr(2'd0, 32'h0);
        tick(); tick(); tick();

        // Masked expiry, then unmasked restart and a CTRL write racing the EN clear
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        tick(); tick();
        tick(); chk(2'd2, 32'd0, 1, 0, "mk_cnt0");
        tick(); chk(2'd0, 32'h0, 1, 0, "mk_en_clr");
        wr(2'd0, 32'h9);
        tick();
        tick(); chk(2'd2, 32'd1, 1, 0, "mk_cnt1");
        tick(); chk(2'd2, 32'd0, 1, 1, "mk_irq");
        wr(2'd0, 32'h9);
        chk(2'd0, 32'h9, 1, 0, "sim_sw_wins");
        tick();
        tick(); chk(2'd2, 32'd1, 1, 0, "sim_restart_cnt");
        tick(); chk(2'd2, 32'd0, 1, 1, "sim_restart_irq");
        wr(2'd0, 32'h0);
        chk(2'd0, 32'h0, 1, 0, "sim_off");

        // Pause and preset change
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        tick();
        tick(); chk(2'd2, 32'd10, 0, 0, "pz_cnt10");
        tick(); chk(2'd2, 32'd9, 0, 0, "pz_cnt9");
        tick(); chk(2'd2, 32'd8, 0, 0, "pz_cnt8");
        wr(2'd0, 32'h0);
        chk(2'd2, 32'd7, 0, 0, "pz_cnt7");
        tick(); chk(2'd2, 32'd7, 0, 0, "pz_hold1");
        tick(); chk(2'd2, 32'd7, 0, 0, "pz_hold2");
        wr(2'd1, 32'd4);
        chk(2'd2, 32'd7, 0, 0, "pz_hold_preset");
        wr(2'd0, 32'h1);
        tick(); chk(2'd2, 32'd7, 0, 0, "pz_in_load");
        tick(); chk(2'd2, 32'd4, 1, 0, "pz_reload4");
        wr(2'd0, 32'h0);
        tick(); chk(2'd2, 32'd3, 0, 0, "pz_stopped");

        // Bus rules
        wr(2'd2, 32'h1234);
        chk(2'd2, 32'd3, 0, 0, "bus_count_ro");
        wr(2'd3, 32'h5678);
        chk(2'd3, 32'd0, 0, 0, "bus_rsvd");
        wr(2'd0, 32'hFFFF_FFFF);
        chk(2'd0, 32'hF, 1, 0, "bus_ctrl_upper");
        wr(2'd0, 32'h0);
        tick(); tick();
        chk(2'd1, 32'd4, 0, 0, "bus_preset");

        // Reset in mid-count
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        tick(); tick(); tick(); tick();
        tick(); chk(2'd2, 32'd5, 1, 0, "rm_cnt5");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk(2'd0, 32'd0, 1, 0, "rm_ctrl");
        tick(); chk(2'd1, 32'd0, 1, 0, "rm_preset");
        tick(); chk(2'd2, 32'd0, 1, 0, "rm_count");
        tick(); tick(); tick();
        chk(2'd2, 32'd0, 1, 0, "rm_stay_idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks still queued, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
